// File: rtl/dm_pkg.sv
// Shared definitions for the CPU/DMA data-memory controller: FSM state codes,
// memop codes, lane widths and the alignment/lane-mask helpers.
package dm_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;
  localparam int ADDR_W = 9;
  localparam int WIDX_W = ADDR_W - 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;

  localparam logic [1:0] MEMOP_B = 2'b00;
  localparam logic [1:0] MEMOP_H = 2'b01;
  localparam logic [1:0] MEMOP_W = 2'b10;
  localparam logic [1:0] MEMOP_X = 2'b11;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        memop;
    logic              sext;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

  // Misaligned halfword/word or the illegal memop code.
  function automatic logic op_err(input logic [1:0] memop, input logic [1:0] off);
    logic e;
    case (memop)
      MEMOP_B: e = 1'b0;
      MEMOP_H: e = off[0];
      MEMOP_W: e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] memop, input logic [1:0] off);
    logic [LANES-1:0] m;
    case (memop)
      MEMOP_B: m = 4'b0001 << off;
      MEMOP_H: m = 4'b0011 << off;
      MEMOP_W: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational byte-lane unit: little-endian extract with zero/sign extension
// for loads, and byte-masked merge of store data into a read word.
module dm_lane
  import dm_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        memop_i,
  input  logic              sext_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] wshift_s;
  logic [LANES-1:0]  mask_s;

  // Load path: pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_s = word_i[{off_i, 3'b000} +: 8];
    half_s = word_i[{off_i[1], 4'b0000} +: 16];
    case (memop_i)
      MEMOP_B: rdata_o = {{24{sext_i & byte_s[7]}}, byte_s};
      MEMOP_H: rdata_o = {{16{sext_i & half_s[15]}}, half_s};
      MEMOP_W: rdata_o = word_i;
      default: rdata_o = {DATA_W{1'b0}};
    endcase
  end

  // Store path: shift right-aligned store data into place and replace masked lanes.
  always_comb begin
    wshift_s = wdata_i << {off_i, 3'b000};
    mask_s   = lane_mask(memop_i, off_i);
    merged_o = word_i;
    for (int i = 0; i < LANES; i++) begin
      if (mask_s[i]) begin
        merged_o[i*8 +: 8] = wshift_s[i*8 +: 8];
      end else begin
        merged_o[i*8 +: 8] = word_i[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory controller shared by a CPU (port 0) and a DMA (port 1) with
// round-robin arbitration, sub-word loads and read-modify-write sub-word stores.
module dm_ctrl
  import dm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_0,
  input  logic                we_0,
  input  logic [ADDR_W-1:0]   addr_0,
  input  logic [1:0]          memop_0,
  input  logic                sext_0,
  input  logic [DATA_W-1:0]   wdata_0,
  output logic                ack_0,
  output logic                err_0,
  output logic [DATA_W-1:0]   rdata_0,
  input  logic                req_1,
  input  logic                we_1,
  input  logic [ADDR_W-1:0]   addr_1,
  input  logic [1:0]          memop_1,
  input  logic                sext_1,
  input  logic [DATA_W-1:0]   wdata_1,
  output logic                ack_1,
  output logic                err_1,
  output logic [DATA_W-1:0]   rdata_1,
  output logic                mem_we,
  output logic [WIDX_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  dm_req_t           cur_q, cur_d;
  dm_req_t           win_s;
  logic              win_id_s;
  logic              cur_err_s;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];
  logic              mem_we_q, mem_we_d;
  logic [WIDX_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] lane_rdata_s, lane_merged_s;

  dm_lane u_lane (
    .word_i   (mem_rdata),
    .off_i    (cur_q.addr[1:0]),
    .memop_i  (cur_q.memop),
    .sext_i   (cur_q.sext),
    .wdata_i  (cur_q.wdata),
    .rdata_o  (lane_rdata_s),
    .merged_o (lane_merged_s)
  );

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    if (req_0 && req_1) begin
      win_id_s = ~last_q;
    end else if (req_1) begin
      win_id_s = 1'b1;
    end else begin
      win_id_s = 1'b0;
    end
    if (win_id_s) begin
      win_s = {we_1, addr_1, memop_1, sext_1, wdata_1};
    end else begin
      win_s = {we_0, addr_0, memop_0, sext_0, wdata_0};
    end
  end

  // Next-state and output computation for the IDLE/ACCESS/WRITE sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cur_d       = cur_q;
    ack_d       = 2'b00;
    err_d       = 2'b00;
    rdata_d     = rdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cur_err_s   = op_err(cur_q.memop, cur_q.addr[1:0]);
    case (state_q)
      ST_IDLE: begin
        if (req_0 || req_1) begin
          state_d     = ST_ACCESS;
          last_d      = win_id_s;
          grant_d     = win_id_s;
          cur_d       = win_s;
          mem_addr_d  = win_s.addr[ADDR_W-1:2];
          mem_wdata_d = win_s.wdata;
          // Word stores write during ACCESS, so their enable is decided here.
          mem_we_d    = win_s.we && (win_s.memop == MEMOP_W) &&
                        !op_err(win_s.memop, win_s.addr[1:0]);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        mem_addr_d = cur_q.addr[ADDR_W-1:2];
        if (cur_err_s) begin
          ack_d[grant_q]   = 1'b1;
          err_d[grant_q]   = 1'b1;
          rdata_d[grant_q] = {DATA_W{1'b0}};
          state_d          = ST_IDLE;
        end else if (!cur_q.we) begin
          ack_d[grant_q]   = 1'b1;
          rdata_d[grant_q] = lane_rdata_s;
          state_d          = ST_IDLE;
        end else if (cur_q.memop == MEMOP_W) begin
          ack_d[grant_q]   = 1'b1;
          rdata_d[grant_q] = {DATA_W{1'b0}};
          state_d          = ST_IDLE;
        end else begin
          mem_we_d    = 1'b1;
          mem_wdata_d = lane_merged_s;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ack_d[grant_q]   = 1'b1;
        rdata_d[grant_q] = {DATA_W{1'b0}};
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      cur_q       <= '0;
      ack_q       <= 2'b00;
      err_q       <= 2'b00;
      rdata_q[0]  <= {DATA_W{1'b0}};
      rdata_q[1]  <= {DATA_W{1'b0}};
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {WIDX_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      cur_q       <= cur_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q[0]  <= rdata_d[0];
      rdata_q[1]  <= rdata_d[1];
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack_0     = ack_q[0];
  assign ack_1     = ack_q[1];
  assign err_0     = err_q[0];
  assign err_1     = err_q[1];
  assign rdata_0   = rdata_q[0];
  assign rdata_1   = rdata_q[1];
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: directed scenarios plus randomized traffic
// checked against a byte-array reference memory.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, sext;
  logic [8:0]  addr  [2];
  logic [1:0]  memop [2];
  logic [31:0] wdata [2];
  logic        ack_0, ack_1, err_0, err_1;
  logic [31:0] rdata_0, rdata_1;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [128];
  logic        clr_mem;
  logic [7:0]  ref_bytes [512];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dm_ctrl dut (
    .clk(clk), .rst(rst),
    .req_0(req[0]), .we_0(we[0]), .addr_0(addr[0]), .memop_0(memop[0]),
    .sext_0(sext[0]), .wdata_0(wdata[0]), .ack_0(ack_0), .err_0(err_0), .rdata_0(rdata_0),
    .req_1(req[1]), .we_1(we[1]), .addr_1(addr[1]), .memop_1(memop[1]),
    .sext_1(sext[1]), .wdata_1(wdata[1]), .ack_1(ack_1), .err_1(err_1), .rdata_1(rdata_1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory behind the controller.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'd0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // ---------------- reference model (byte-addressed) ----------------
  function automatic logic ref_err(input logic [8:0] a, input logic [1:0] op);
    return (op == 2'b11) || (op == 2'b01 && a[0]) || (op == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input logic [8:0] a, input logic [1:0] op, input logic s);
    int sz;
    longint v;
    sz = 1 << op;
    v  = 0;
    for (int i = 0; i < sz; i++) v += longint'(ref_bytes[int'(a) + i]) << (8 * i);
    if (s && sz < 4 && ref_bytes[int'(a) + sz - 1][7]) v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [8:0] a, input logic [1:0] op, input logic [31:0] d);
    int sz;
    sz = 1 << op;
    for (int i = 0; i < sz; i++) ref_bytes[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  function automatic int ref_lat(input logic w, input logic [8:0] a, input logic [1:0] op);
    if (ref_err(a, op)) return 2;
    if (w && op != 2'b10) return 3;
    return 2;
  endfunction

  // Drives one request on port n and reports what the DUT did; no checking here.
  task automatic run_txn(input int n, input logic w, input logic [8:0] a, input logic [1:0] op,
                         input logic s, input logic [31:0] d, output int lat, output logic e,
                         output logic [31:0] rd, output int wec, output logic other);
    @(posedge clk); #1;
    req[n] = 1'b1; we[n] = w; addr[n] = a; memop[n] = op; sext[n] = s; wdata[n] = d;
    lat = 0; e = 1'b0; rd = 32'd0; wec = 0; other = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (mem_we) wec++;
      if (n == 0 ? ack_1 : ack_0) other = 1'b1;
      if (n == 0 ? ack_0 : ack_1) begin
        lat = c;
        e   = (n == 0) ? err_0 : err_1;
        rd  = (n == 0) ? rdata_0 : rdata_1;
        req[n] = 1'b0;
        break;
      end
    end
    req[n] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; clr_mem = 1'b1;
    req = 2'b00; we = 2'b00; sext = 2'b00;
    for (int i = 0; i < 2; i++) begin addr[i] = 9'd0; memop[i] = 2'b00; wdata[i] = 32'd0; end
    for (int i = 0; i < 512; i++) ref_bytes[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({ack_0, ack_1, err_0, err_1} !== 4'b0000) begin n_bad++; $display("FAIL reset_ack_err got %b want 0000", {ack_0, ack_1, err_0, err_1}); end
    n_cmp++; if (rdata_0 !== 32'd0 || rdata_1 !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got %h/%h want 0", rdata_0, rdata_1); end
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 7'd0 || mem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_mem got we=%b addr=%h wd=%h want 0", mem_we, mem_addr, mem_wdata); end
    clr_mem = 1'b0; rst = 1'b0;
  endtask

  task automatic test_word_store_load;
    int lat, wec; logic e, oth; logic [31:0] rd;
    run_txn(0, 1'b1, 9'h010, 2'b10, 1'b0, 32'hDEADBEEF, lat, e, rd, wec, oth);
    ref_store(9'h010, 2'b10, 32'hDEADBEEF);
    n_cmp++; if (lat !== 2 || e !== 1'b0 || wec !== 1) begin n_bad++; $display("FAIL wstore got lat=%0d err=%b we=%0d want 2/0/1", lat, e, wec); end
    run_txn(0, 1'b0, 9'h010, 2'b10, 1'b0, 32'd0, lat, e, rd, wec, oth);
    n_cmp++; if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat !== 2 || wec !== 0) begin n_bad++; $display("FAIL wload got rd=%h err=%b lat=%0d we=%0d want deadbeef/0/2/0", rd, e, lat, wec); end
  endtask

  task automatic test_byte_rmw;
    int lat, wec; logic e, oth; logic [31:0] rd;
    run_txn(0, 1'b1, 9'h020, 2'b10, 1'b0, 32'h11223344, lat, e, rd, wec, oth);
    ref_store(9'h020, 2'b10, 32'h11223344);
    run_txn(1, 1'b1, 9'h021, 2'b00, 1'b0, 32'h000000AA, lat, e, rd, wec, oth);
    ref_store(9'h021, 2'b00, 32'h000000AA);
    n_cmp++; if (lat !== 3 || e !== 1'b0 || wec !== 1 || oth !== 1'b0) begin n_bad++; $display("FAIL byte_rmw got lat=%0d err=%b we=%0d oth=%b want 3/0/1/0", lat, e, wec, oth); end
    run_txn(1, 1'b0, 9'h020, 2'b10, 1'b0, 32'd0, lat, e, rd, wec, oth);
    n_cmp++; if (rd !== 32'h1122AA44) begin n_bad++; $display("FAIL byte_rmw_word got %h want 1122aa44", rd); end
  endtask

  task automatic test_signed_half;
    int lat, wec; logic e, oth; logic [31:0] rd;
    run_txn(0, 1'b1, 9'h030, 2'b10, 1'b0, 32'h8001F234, lat, e, rd, wec, oth);
    ref_store(9'h030, 2'b10, 32'h8001F234);
    run_txn(0, 1'b0, 9'h032, 2'b01, 1'b1, 32'd0, lat, e, rd, wec, oth);
    n_cmp++; if (rd !== 32'hFFFF8001 || e !== 1'b0) begin n_bad++; $display("FAIL half_sext got %h err=%b want ffff8001", rd, e); end
    run_txn(0, 1'b0, 9'h032, 2'b01, 1'b0, 32'd0, lat, e, rd, wec, oth);
    n_cmp++; if (rd !== 32'h00008001 || e !== 1'b0) begin n_bad++; $display("FAIL half_zext got %h err=%b want 00008001", rd, e); end
  endtask

  task automatic test_misaligned;
    int lat, wec; logic e, oth; logic [31:0] rd;
    run_txn(0, 1'b0, 9'h005, 2'b10, 1'b0, 32'd0, lat, e, rd, wec, oth);
    n_cmp++; if (lat !== 2 || e !== 1'b1 || rd !== 32'd0 || wec !== 0) begin n_bad++; $display("FAIL misalign_wload got lat=%0d err=%b rd=%h we=%0d want 2/1/0/0", lat, e, rd, wec); end
    run_txn(1, 1'b1, 9'h003, 2'b01, 1'b0, 32'h0000BEEF, lat, e, rd, wec, oth);
    n_cmp++; if (lat !== 2 || e !== 1'b1 || wec !== 0) begin n_bad++; $display("FAIL misalign_hstore got lat=%0d err=%b we=%0d want 2/1/0", lat, e, wec); end
    run_txn(1, 1'b1, 9'h000, 2'b11, 1'b0, 32'h12345678, lat, e, rd, wec, oth);
    n_cmp++; if (lat !== 2 || e !== 1'b1 || rd !== 32'd0 || wec !== 0) begin n_bad++; $display("FAIL illegal_op got lat=%0d err=%b rd=%h we=%0d want 2/1/0/0", lat, e, rd, wec); end
  endtask

  task automatic test_contention;
    int order[$];
    logic [31:0] got[$];
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    we = 2'b00; sext = 2'b00; req = 2'b11;
    addr[0] = 9'h010; memop[0] = 2'b10;
    addr[1] = 9'h030; memop[1] = 2'b10;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(posedge clk); #1;
      if (ack_0 && ack_1) begin order.push_back(9); got.push_back(32'd0); end
      else if (ack_0) begin order.push_back(0); got.push_back(rdata_0); end
      else if (ack_1) begin order.push_back(1); got.push_back(rdata_1); end
    end
    req = 2'b00;
    n_cmp++; if (order.size() !== 4) begin n_bad++; $display("FAIL contention_count got %0d acks want 4", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      n_cmp++; if (order[k] !== k % 2) begin n_bad++; $display("FAIL contention_order idx %0d got %0d want %0d", k, order[k], k % 2); end
      n_cmp++; if (got[k] !== ref_load(k % 2 == 0 ? 9'h010 : 9'h030, 2'b10, 1'b0)) begin n_bad++; $display("FAIL contention_rdata idx %0d got %h", k, got[k]); end
    end
  endtask

  task automatic test_random;
    int lat, wec, n; logic e, oth, w, s; logic [31:0] rd, d, exp_rd; logic [8:0] a; logic [1:0] op;
    for (int t = 0; t < 80; t++) begin
      n  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      a  = 9'($urandom_range(0, 511));
      d  = $urandom;
      if ($urandom_range(0, 3) != 0 && op != 2'b11) a = a & ~(9'((1 << op) - 1));
      exp_rd = ref_err(a, op) ? 32'd0 : ref_load(a, op, s);
      run_txn(n, w, a, op, s, d, lat, e, rd, wec, oth);
      if (!ref_err(a, op) && w) ref_store(a, op, d);
      n_cmp++; if (lat !== ref_lat(w, a, op) || e !== ref_err(a, op) || oth !== 1'b0) begin n_bad++; $display("FAIL rand_ctl t%0d p%0d got lat=%0d err=%b oth=%b want %0d/%b/0", t, n, lat, e, oth, ref_lat(w, a, op), ref_err(a, op)); end
      n_cmp++; if (wec !== ((w && !ref_err(a, op)) ? 1 : 0)) begin n_bad++; $display("FAIL rand_we t%0d got %0d we cycles", t, wec); end
      if (!w || ref_err(a, op)) begin
        n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL rand_rdata t%0d a=%h op=%0d s=%b got %h want %h", t, a, op, s, rd, exp_rd); end
      end
    end
  endtask

  task automatic test_reset_in_write;
    int lat, wec; logic e, oth; logic [31:0] rd;
    logic seen_ack;
    run_txn(0, 1'b1, 9'h040, 2'b10, 1'b0, 32'h55667788, lat, e, rd, wec, oth);
    ref_store(9'h040, 2'b10, 32'h55667788);
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'h041; memop[0] = 2'b00; sext[0] = 1'b0; wdata[0] = 32'h00000099;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_write_reached got mem_we=%b want 1", mem_we); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0 || ack_0 !== 1'b0) begin n_bad++; $display("FAIL rst_write_abort got we=%b ack=%b want 0/0", mem_we, ack_0); end
    req[0] = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    seen_ack = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack_0 || ack_1) seen_ack = 1'b1; end
    n_cmp++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL rst_write_noack got ack after reset"); end
    run_txn(0, 1'b0, 9'h040, 2'b10, 1'b0, 32'd0, lat, e, rd, wec, oth);
    n_cmp++; if (rd !== 32'h55667788 || lat !== 2) begin n_bad++; $display("FAIL rst_write_mem got %h lat=%0d want 55667788/2", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_signed_half();
    test_misaligned();
    test_contention();
    test_random();
    test_reset_in_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
DM_CTRL -- requirements
Module: dm_ctrl

Interface
REQ-001 SHALL expose: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL expose: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose per requester n in {0,1} (0 = CPU, 1 = DMA): req_n  input  1  access request.
REQ-004 SHALL expose: we_n  input  1  1 = store, 0 = load.
REQ-005 SHALL expose: addr_n  input  9  byte address [8:0].
REQ-006 SHALL expose: memop_n  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL expose: sext_n  input  1  sign-extend load result.
REQ-008 SHALL expose: wdata_n  input  32  store data, right-aligned.
REQ-009 SHALL expose: ack_n  output  1  one-cycle completion pulse.
REQ-010 SHALL expose: err_n  output  1  misalignment or illegal-op flag, valid with ack_n.
REQ-011 SHALL expose: rdata_n  output  32  load result, valid with ack_n.
REQ-012 SHALL expose: mem_we  output  1  word memory write enable.
REQ-013 SHALL expose: mem_addr  output  7  word index [8:2].
REQ-014 SHALL expose: mem_wdata  output  32  word write data.
REQ-015 SHALL expose: mem_rdata  input  32  combinational word read of mem_addr.

Function
REQ-016 SHALL use states IDLE, ACCESS, WRITE.
REQ-017 IDLE: if any req_n, SHALL latch winner's we/addr/memop/sext/wdata and go to ACCESS; otherwise stay.
REQ-018 Arbitration SHALL be round-robin: sole requester wins; on simultaneous requests, the requester not granted last wins.
REQ-019 ACCESS, word load: SHALL drive mem_addr, pulse ack, drive rdata = mem_rdata, and return to IDLE (latency 2 cycles from req sampled to ack).
REQ-020 ACCESS, byte/half load: SHALL select lane by addr[1:0] (little-endian), zero- or sign-extend per sext, ack, and return to IDLE.
REQ-021 ACCESS, word store: SHALL assert mem_we with mem_wdata = wdata, ack, and return to IDLE.
REQ-022 ACCESS, byte/half store: SHALL register mem_rdata and go to WRITE; WRITE SHALL write the merged word (only the addressed lanes replaced), ack, and return to IDLE (latency 3 cycles).
REQ-023 Halfword with addr[0]=1, word with addr[1:0]!=0, or memop=11: SHALL pulse ack and err in ACCESS, return rdata=0, and never assert mem_we.
REQ-024 Requester SHALL hold req and fields stable until ack; req still high in the cycle after ack is a new request.
REQ-025 ack_n/err_n/rdata_n SHALL be registered outputs; non-granted requester's ack/err SHALL stay 0.
REQ-026 mem_we SHALL be high for at most one cycle per transaction.

Reset
REQ-027 rst SHALL force state=IDLE, all ack/err=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, and the last-grant pointer to 1 (CPU wins the first tie).
REQ-028 rst mid-transaction SHALL abort it with no ack and no partial write.

Structure
REQ-029 State encoding, memop codes (MEMOP_B/H/W) and lane-merge widths SHALL be defined in a shared package dm_pkg.
REQ-030 Lane extract/merge logic SHALL live in one combinational sub-module dm_lane (extract+extend, merge by byte mask).

Verification
REQ-031 Word store then load: m0 store 0xDEADBEEF @0x010, then load @0x010 -> mem_we one cycle, rdata_0=0xDEADBEEF, err_0=0.
REQ-032 Byte store RMW: word @0x020=0x11223344; m1 store byte 0xAA @0x021 -> word 0x1122AA44, ack_1 three cycles after req.
REQ-033 Signed half load: word @0x030=0x8001F234; load half @0x032 sext=1 -> 0xFFFF8001; sext=0 -> 0x00008001.
REQ-034 Misaligned: m0 word load @0x005 -> ack_0=err_0=1, rdata_0=0, no mem_we.
REQ-035 Contention: req_0 and req_1 held high together after reset -> grants alternate 0,1,0,1; neither starves.
REQ-036 Reset during WRITE of byte store -> memory word unchanged, no ack, state IDLE.
